// File: rtl/float_divider_seq_if.sv
// ---------------------------------------------------------------------------
// float_divider_seq_if
// Purpose : Bundles the start/busy/done handshake and operand/result buses
//           of the sequential single-precision divider.
// Signals : start    - request; only taken while the divider is idle
//           dividend - IEEE-754 single, captured when a request is taken
//           divisor  - IEEE-754 single, captured when a request is taken
//           result   - quotient, refreshed only on the done cycle
//           busy     - high while a division is in progress
//           done     - one-cycle pulse marking result valid
//           divZero  - divisor was +/-0; refreshed together with result
// Modports: master drives the request side; slave is the divider itself.
// ---------------------------------------------------------------------------
interface float_divider_seq_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        divZero;

    modport master (
        output start, dividend, divisor,
        input  result, busy, done, divZero
    );

    modport slave (
        input  start, dividend, divisor,
        output result, busy, done, divZero
    );
endinterface

// File: rtl/float_divider_seq.sv
// ---------------------------------------------------------------------------
// float_divider_seq
// Purpose : Iterative IEEE-754 single-precision divider. Restoring division of
//           the significands produces one quotient bit per clock (26 bits),
//           followed by a single normalise/round step. Rounding is half-up on
//           the first dropped bit. Normal operands only; a zero divisor gives
//           signed infinity with divZero set, a zero dividend gives signed
//           zero. Fixed latency: done is high in the cycle after the 27th
//           clock edge following the accepted start.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous, active-high reset
//           bus  - float_divider_seq_if.slave (start/operands in,
//                  result/busy/done/divZero out)
// ---------------------------------------------------------------------------
module float_divider_seq (
    input  logic                  clk,
    input  logic                  rst,
    float_divider_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [23:0] nb_q,      nb_d;
    logic [24:0] rem_q,     rem_d;
    logic [25:0] quo_q,     quo_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic        sign_q,    sign_d;
    logic [7:0]  expA_q,    expA_d;
    logic [7:0]  expB_q,    expB_d;
    logic        aZero_q,   aZero_d;
    logic        bZero_q,   bZero_d;
    logic [31:0] result_q,  result_d;
    logic        done_q,    done_d;
    logic        divZero_q, divZero_d;

    // One restoring-division step: subtract the divisor when it fits, then
    // shift the partial remainder left. The remainder always stays below
    // 2*Nb, so the shifted value fits in 25 bits.
    logic        qBit;
    logic [24:0] remSub;
    logic [24:0] remKeep;

    always_comb begin
        qBit    = (rem_q >= {1'b0, nb_q});
        remSub  = rem_q - {1'b0, nb_q};
        remKeep = qBit ? remSub : rem_q;
    end

    // Normalise and round the finished quotient. The quotient lies in
    // [2^24, 2^26), so only its top bit decides the one-place normalise.
    // Adding the round bit to the 23-bit fraction wraps to zero exactly when
    // {1,F}+r would carry out, and that carry bumps the exponent.
    logic [22:0] fracRaw;
    logic        roundBit;
    logic [7:0]  expRaw;
    logic [22:0] fracRnd;
    logic [7:0]  expRnd;
    logic        carry;

    always_comb begin
        if (quo_q[25]) begin
            fracRaw  = quo_q[24:2];
            roundBit = quo_q[1];
            expRaw   = expA_q - expB_q + 8'd127;
        end else begin
            fracRaw  = quo_q[23:1];
            roundBit = quo_q[0];
            expRaw   = expA_q - expB_q + 8'd126;
        end
        carry   = (&fracRaw) & roundBit;
        fracRnd = fracRaw + {22'd0, roundBit};
        expRnd  = expRaw + {7'd0, carry};
    end

    // Next-state and datapath control. Everything holds by default; done
    // is a single-cycle pulse so it defaults low.
    always_comb begin
        state_d   = state_q;
        nb_d      = nb_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        expA_d    = expA_q;
        expB_d    = expB_q;
        aZero_d   = aZero_q;
        bZero_d   = bZero_q;
        result_d  = result_q;
        divZero_d = divZero_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    nb_d    = {1'b1, bus.divisor[22:0]};
                    rem_d   = {2'b01, bus.dividend[22:0]};
                    quo_d   = 26'd0;
                    cnt_d   = 5'd25;
                    sign_d  = bus.dividend[31] ^ bus.divisor[31];
                    expA_d  = bus.dividend[30:23];
                    expB_d  = bus.divisor[30:23];
                    aZero_d = (bus.dividend[30:0] == 31'd0);
                    bZero_d = (bus.divisor[30:0] == 31'd0);
                    state_d = CALC;
                end
            end

            CALC: begin
                rem_d = remKeep << 1;
                quo_d = {quo_q[24:0], qBit};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = ROUND;
                end
            end

            ROUND: begin
                // Special operands override the datapath; a zero divisor
                // takes priority over a zero dividend.
                if (bZero_q) begin
                    result_d  = {sign_q, 8'hFF, 23'd0};
                    divZero_d = 1'b1;
                end else if (aZero_q) begin
                    result_d  = {sign_q, 31'd0};
                    divZero_d = 1'b0;
                end else begin
                    result_d  = {sign_q, expRnd, fracRnd};
                    divZero_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset aborts any operation in flight and clears the
    // visible outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            nb_q      <= 24'd0;
            rem_q     <= 25'd0;
            quo_q     <= 26'd0;
            cnt_q     <= 5'd0;
            sign_q    <= 1'b0;
            expA_q    <= 8'd0;
            expB_q    <= 8'd0;
            aZero_q   <= 1'b0;
            bZero_q   <= 1'b0;
            result_q  <= 32'd0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nb_q      <= nb_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            expA_q    <= expA_d;
            expB_q    <= expB_d;
            aZero_q   <= aZero_d;
            bZero_q   <= bZero_d;
            result_q  <= result_d;
            done_q    <= done_d;
            divZero_q <= divZero_d;
        end
    end

    assign bus.result  = result_q;
    assign bus.done    = done_q;
    assign bus.divZero = divZero_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_float_divider_seq.sv
// ---------------------------------------------------------------------------
// tb_float_divider_seq
// Purpose : Directed bench for float_divider_seq. Operand pairs have
//           hand-worked quotients; latency, handshake behaviour (ignored
//           start while busy, back-to-back start on the done cycle) and
//           mid-operation reset are exercised as a linear sequence of steps.
// ---------------------------------------------------------------------------
module tb_float_divider_seq;

    logic clk;
    logic rst;
    int   checks;
    int   passed;
    int   failed;

    float_divider_seq_if bus ();

    float_divider_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-derived expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present a request and hold start across exactly one rising edge (E0).
    // Returns 1 time unit after that edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count edges until done is seen, with a hard bound so a dead DUT
    // shows up as a wrong latency rather than a hang.
    task automatic waitDone(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles = cycles + 1;
        end while (bus.done !== 1'b1 && cycles < 60);
    endtask

    // Count done pulses over a window where none are expected.
    task automatic countDones(input int window, output int dones);
        dones = 0;
        for (int i = 0; i < window; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones = dones + 1;
        end
    endtask

    // Full operation: launch, wait, check latency, result, flags.
    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expResult, input logic expDivZero);
        int cycles;
        applyStimulus(a, b);
        waitDone(cycles);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd27);
        checkOutput({tag, "_result"}, bus.result, expResult);
        checkOutput({tag, "_divzero"}, {31'd0, bus.divZero}, {31'd0, expDivZero});
        checkOutput({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int cycles;
        int dones;

        checks       = 0;
        passed       = 0;
        failed       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_result", bus.result, 32'd0);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset_divzero", {31'd0, bus.divZero}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic quotients, rounding paths and special operands.
        runOp("t1_6div2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        runOp("t2_1div3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
        runOp("t3_neg", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0);
        runOp("t4_divzero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1);
        runOp("t4_zerodiv", 32'h80000000, 32'h40000000, 32'h80000000, 1'b0);
        runOp("one_div_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
        runOp("near_one", 32'h3F7FFFFE, 32'h3F7FFFFF, 32'h3F7FFFFF, 1'b0);

        // Start re-pulsed while busy must be ignored.
        applyStimulus(32'h40C00000, 32'h40000000);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("t5_busy_mid", {31'd0, bus.busy}, 32'd1);
        bus.start    = 1'b1;
        bus.dividend = 32'h3F800000;
        bus.divisor  = 32'h40400000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        waitDone(cycles);
        checkOutput("t5_ignored_latency", 32'(cycles + 6), 32'd27);
        checkOutput("t5_ignored_result", bus.result, 32'h40400000);
        countDones(35, dones);
        checkOutput("t5_single_done", 32'(dones), 32'd0);
        checkOutput("t5_idle_after", {31'd0, bus.busy}, 32'd0);

        // Start held during the done cycle is accepted immediately.
        applyStimulus(32'h3F800000, 32'h40400000);
        waitDone(cycles);
        checkOutput("t5_b2b_first_latency", 32'(cycles), 32'd27);
        checkOutput("t5_b2b_first_result", bus.result, 32'h3EAAAAAB);
        applyStimulus(32'hBFC00000, 32'h3F000000);
        checkOutput("t5_b2b_done_pulse", {31'd0, bus.done}, 32'd0);
        checkOutput("t5_b2b_busy", {31'd0, bus.busy}, 32'd1);
        waitDone(cycles);
        checkOutput("t5_b2b_second_latency", 32'(cycles), 32'd27);
        checkOutput("t5_b2b_second_result", bus.result, 32'hC0400000);

        // Reset in the middle of an operation aborts it.
        applyStimulus(32'h40C00000, 32'h40000000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("t6_rst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("t6_rst_result", bus.result, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        countDones(35, dones);
        checkOutput("t6_no_done", 32'(dones), 32'd0);
        runOp("t6_fresh", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
